// File: rtl/sim_halt_monitor.sv
// Simulation-termination monitor: detects EBREAK, watchdog idle and cycle-limit events,
// drains in-flight writes, then holds a sticky halt with exit code, PC and counters.
module sim_halt_monitor #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned CNT_W        = 64,
    parameter logic [31:0] EBREAK_INST  = 32'h00100073,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 0,
    parameter int unsigned MAX_CYCLES   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  a0,
    output logic             stop,
    output logic             halt,
    output logic [1:0]       halt_reason,
    output logic [XLEN-1:0]  exit_code,
    output logic [XLEN-1:0]  halt_pc,
    output logic             good,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    localparam logic [1:0] REASON_EBREAK   = 2'd1;
    localparam logic [1:0] REASON_WATCHDOG = 2'd2;
    localparam logic [1:0] REASON_LIMIT    = 2'd3;

    state_t             state, state_next;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [WD_W-1:0]    wd_cnt;
    logic [XLEN-1:0]    last_pc;
    logic               trap, wd_fire, limit_fire;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        trap       = 1'b0;
        wd_fire    = 1'b0;
        limit_fire = 1'b0;
        if (state == RUN) begin
            trap       = inst_valid && (inst == EBREAK_INST);
            wd_fire    = (TIMEOUT > 0) && !inst_valid && (wd_cnt == WD_W'(TIMEOUT - 1));
            limit_fire = (MAX_CYCLES > 0) && (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (trap)
                    state_next = (DRAIN_CYCLES > 0) ? DRAIN : HALT;
                else if (wd_fire || limit_fire)
                    state_next = HALT;
            end
            DRAIN:   if (drain_cnt == '0) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_reason <= '0;
            exit_code   <= '0;
            halt_pc     <= '0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            wd_cnt      <= '0;
            drain_cnt   <= '0;
            last_pc     <= '0;
        end else begin
            if (state != HALT && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + CNT_W'(1);

            if (state == RUN) begin
                if (inst_valid) begin
                    if (instret_cnt != '1)
                        instret_cnt <= instret_cnt + CNT_W'(1);
                    last_pc <= pc;
                    wd_cnt  <= '0;
                end else if (TIMEOUT > 0) begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                end

                // Priority: ebreak, then watchdog, then cycle limit.
                if (trap) begin
                    halt_reason <= REASON_EBREAK;
                    exit_code   <= a0;
                    halt_pc     <= pc;
                    drain_cnt   <= DRAIN_W'(DRAIN_CYCLES - 1);
                end else if (wd_fire) begin
                    halt_reason <= REASON_WATCHDOG;
                    exit_code   <= '1;
                    halt_pc     <= last_pc;
                end else if (limit_fire) begin
                    halt_reason <= REASON_LIMIT;
                    exit_code   <= '1;
                    halt_pc     <= inst_valid ? pc : last_pc;
                end
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
        end
    end

    assign stop = (state != RUN);
    assign halt = (state == HALT);
    assign good = halt && (halt_reason == REASON_EBREAK) && (exit_code == '0);

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Bench for sim_halt_monitor: four instances (drain 2, drain 0, watchdog 8, limit 100)
// share one stimulus stream; directed scenarios plus randomized runs against an event-time model.
module tb_sim_halt_monitor;

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] ECALL  = 32'h00000073;
    localparam longint      NEVER  = 64'sh0fff_ffff_ffff_ffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] inst = NOP;
    logic [31:0] pc = '0;
    logic [31:0] a0 = '0;

    logic        stop_o[4];
    logic        halt_o[4];
    logic        good_o[4];
    logic [1:0]  reason_o[4];
    logic [31:0] exit_o[4];
    logic [31:0] hpc_o[4];
    logic [63:0] cyc_o[4];
    logic [63:0] ret_o[4];

    always #5 clk = ~clk;

    // 0: drain 2, 1: drain 0, 2: watchdog 8, 3: cycle limit 100
    for (genvar g = 0; g < 4; g++) begin : g_dut
        sim_halt_monitor #(
            .DRAIN_CYCLES ((g == 1) ? 0 : 2),
            .TIMEOUT      ((g == 2) ? 8 : 0),
            .MAX_CYCLES   ((g == 3) ? 100 : 0)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .inst_valid  (inst_valid),
            .inst        (inst),
            .pc          (pc),
            .a0          (a0),
            .stop        (stop_o[g]),
            .halt        (halt_o[g]),
            .halt_reason (reason_o[g]),
            .exit_code   (exit_o[g]),
            .halt_pc     (hpc_o[g]),
            .good        (good_o[g]),
            .cycle_cnt   (cyc_o[g]),
            .instret_cnt (ret_o[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each instance is described by the cycle index at which it stops and halts.
    int          drain_cfg[4] = '{2, 0, 2, 2};
    int          to_cfg[4]    = '{0, 0, 8, 0};
    int          max_cfg[4]   = '{0, 0, 0, 100};
    longint      t;
    longint      stop_at[4], halt_at[4], idle_run[4], m_ret[4];
    int          m_reason[4];
    logic [31:0] m_exit[4], m_hpc[4], m_last[4];

    task automatic model_reset();
        t = 0;
        for (int k = 0; k < 4; k++) begin
            stop_at[k] = NEVER; halt_at[k] = NEVER; idle_run[k] = 0; m_ret[k] = 0;
            m_reason[k] = 0; m_exit[k] = '0; m_hpc[k] = '0; m_last[k] = '0;
        end
    endtask

    task automatic model_step(input logic v, input logic [31:0] i, input logic [31:0] p, input logic [31:0] a);
        for (int k = 0; k < 4; k++) begin
            if (t < stop_at[k]) begin
                if (v && i == EBREAK) begin
                    m_reason[k] = 1; m_exit[k] = a; m_hpc[k] = p;
                    stop_at[k] = t + 1; halt_at[k] = t + 1 + drain_cfg[k];
                end else if (to_cfg[k] > 0 && !v && idle_run[k] + 1 == to_cfg[k]) begin
                    m_reason[k] = 2; m_exit[k] = '1; m_hpc[k] = m_last[k];
                    stop_at[k] = t + 1; halt_at[k] = t + 1;
                end else if (max_cfg[k] > 0 && t == max_cfg[k] - 1) begin
                    m_reason[k] = 3; m_exit[k] = '1; m_hpc[k] = v ? p : m_last[k];
                    stop_at[k] = t + 1; halt_at[k] = t + 1;
                end
                if (v) begin
                    m_ret[k]++; m_last[k] = p; idle_run[k] = 0;
                end else begin
                    idle_run[k]++;
                end
            end
        end
        t++;
    endtask

    task automatic do_reset();
        rst = 1'b1; inst_valid = 1'b0; inst = NOP; pc = '0; a0 = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] p, input logic [31:0] a);
        inst_valid = v; inst = i; pc = p; a0 = a;
        model_step(v, i, p, a);
        @(posedge clk); #1;
        inst_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 3; c++) cycle(1'b1, NOP, 32'h80000000 + 32'(c * 4), 32'h5);
        cycle(1'b1, EBREAK, 32'h8000000C, 32'h5);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (stop_o[k] !== 1'b0) $display("FAIL reset_stop[%0d]: got %0h want 0", k, stop_o[k]); else n_pass++;
            n_checks++; if (halt_o[k] !== 1'b0) $display("FAIL reset_halt[%0d]: got %0h want 0", k, halt_o[k]); else n_pass++;
            n_checks++; if (reason_o[k] !== 2'd0) $display("FAIL reset_reason[%0d]: got %0h want 0", k, reason_o[k]); else n_pass++;
            n_checks++; if (exit_o[k] !== 32'h0) $display("FAIL reset_exit[%0d]: got %0h want 0", k, exit_o[k]); else n_pass++;
            n_checks++; if (hpc_o[k] !== 32'h0) $display("FAIL reset_hpc[%0d]: got %0h want 0", k, hpc_o[k]); else n_pass++;
            n_checks++; if (cyc_o[k] !== 64'h0) $display("FAIL reset_cycle[%0d]: got %0h want 0", k, cyc_o[k]); else n_pass++;
            n_checks++; if (ret_o[k] !== 64'h0) $display("FAIL reset_instret[%0d]: got %0h want 0", k, ret_o[k]); else n_pass++;
            n_checks++; if (good_o[k] !== 1'b0) $display("FAIL reset_good[%0d]: got %0h want 0", k, good_o[k]); else n_pass++;
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_ebreak_drain();
        do_reset();
        for (int c = 0; c < 5; c++) cycle(1'b1, NOP, 32'h80000000 + 32'(c * 4), 32'h0);
        cycle(1'b1, EBREAK, 32'h80000014, 32'h0);
        n_checks++; if (stop_o[0] !== 1'b1) $display("FAIL drain_stop_t1: got %0h want 1", stop_o[0]); else n_pass++;
        n_checks++; if (halt_o[0] !== 1'b0) $display("FAIL drain_halt_t1: got %0h want 0", halt_o[0]); else n_pass++;
        cycle(1'b0, NOP, 32'h0, 32'h0);
        n_checks++; if (halt_o[0] !== 1'b0) $display("FAIL drain_halt_t2: got %0h want 0", halt_o[0]); else n_pass++;
        cycle(1'b0, NOP, 32'h0, 32'h0);
        n_checks++; if (halt_o[0] !== 1'b1) $display("FAIL drain_halt_t3: got %0h want 1", halt_o[0]); else n_pass++;
        n_checks++; if (reason_o[0] !== 2'd1) $display("FAIL drain_reason: got %0h want 1", reason_o[0]); else n_pass++;
        n_checks++; if (exit_o[0] !== 32'h0) $display("FAIL drain_exit: got %0h want 0", exit_o[0]); else n_pass++;
        n_checks++; if (good_o[0] !== 1'b1) $display("FAIL drain_good: got %0h want 1", good_o[0]); else n_pass++;
        n_checks++; if (hpc_o[0] !== 32'h80000014) $display("FAIL drain_hpc: got %0h want 80000014", hpc_o[0]); else n_pass++;
        n_checks++; if (ret_o[0] !== 64'd6) $display("FAIL drain_instret: got %0d want 6", ret_o[0]); else n_pass++;
        n_checks++; if (cyc_o[0] !== 64'd8) $display("FAIL drain_cycle: got %0d want 8", cyc_o[0]); else n_pass++;
    endtask

    task automatic test_ebreak_nodrain();
        do_reset();
        for (int c = 0; c < 5; c++) cycle(1'b1, NOP, 32'h80000000 + 32'(c * 4), 32'h2A);
        cycle(1'b1, EBREAK, 32'h80000014, 32'h2A);
        n_checks++; if (stop_o[1] !== 1'b1) $display("FAIL nodrain_stop: got %0h want 1", stop_o[1]); else n_pass++;
        n_checks++; if (halt_o[1] !== 1'b1) $display("FAIL nodrain_halt: got %0h want 1", halt_o[1]); else n_pass++;
        n_checks++; if (exit_o[1] !== 32'h2A) $display("FAIL nodrain_exit: got %0h want 2a", exit_o[1]); else n_pass++;
        n_checks++; if (good_o[1] !== 1'b0) $display("FAIL nodrain_good: got %0h want 0", good_o[1]); else n_pass++;
        n_checks++; if (reason_o[1] !== 2'd1) $display("FAIL nodrain_reason: got %0h want 1", reason_o[1]); else n_pass++;
        n_checks++; if (halt_o[0] !== 1'b0) $display("FAIL nodrain_ref_halt: got %0h want 0", halt_o[0]); else n_pass++;
    endtask

    task automatic test_watchdog();
        do_reset();
        cycle(1'b1, NOP, 32'h80000000, 32'h0);
        for (int c = 0; c < 6; c++) cycle(1'b0, NOP, 32'h0, 32'h0);
        cycle(1'b1, NOP, 32'h80000004, 32'h0);
        for (int c = 0; c < 7; c++) cycle(1'b0, NOP, 32'h0, 32'h0);
        n_checks++; if (halt_o[2] !== 1'b0) $display("FAIL wd_restart_halt: got %0h want 0", halt_o[2]); else n_pass++;
        cycle(1'b0, NOP, 32'h0, 32'h0);
        n_checks++; if (halt_o[2] !== 1'b1) $display("FAIL wd_halt: got %0h want 1", halt_o[2]); else n_pass++;
        n_checks++; if (reason_o[2] !== 2'd2) $display("FAIL wd_reason: got %0h want 2", reason_o[2]); else n_pass++;
        n_checks++; if (exit_o[2] !== 32'hFFFFFFFF) $display("FAIL wd_exit: got %0h want ffffffff", exit_o[2]); else n_pass++;
        n_checks++; if (hpc_o[2] !== 32'h80000004) $display("FAIL wd_hpc_restart: got %0h want 80000004", hpc_o[2]); else n_pass++;

        do_reset();
        cycle(1'b1, NOP, 32'h80000000, 32'h0);
        for (int c = 0; c < 7; c++) cycle(1'b0, NOP, 32'h0, 32'h0);
        n_checks++; if (halt_o[2] !== 1'b0) $display("FAIL wd_idle7_halt: got %0h want 0", halt_o[2]); else n_pass++;
        cycle(1'b0, NOP, 32'h0, 32'h0);
        n_checks++; if (halt_o[2] !== 1'b1) $display("FAIL wd_idle8_halt: got %0h want 1", halt_o[2]); else n_pass++;
        n_checks++; if (hpc_o[2] !== 32'h80000000) $display("FAIL wd_hpc: got %0h want 80000000", hpc_o[2]); else n_pass++;
        n_checks++; if (halt_o[0] !== 1'b0) $display("FAIL wd_disabled_halt: got %0h want 0", halt_o[0]); else n_pass++;
    endtask

    task automatic test_cycle_limit();
        do_reset();
        for (int c = 0; c < 99; c++) cycle(1'b1, NOP, 32'h80000000 + 32'(c * 4), 32'h0);
        n_checks++; if (halt_o[3] !== 1'b0) $display("FAIL limit_early_halt: got %0h want 0", halt_o[3]); else n_pass++;
        n_checks++; if (cyc_o[3] !== 64'd99) $display("FAIL limit_cycle99: got %0d want 99", cyc_o[3]); else n_pass++;
        cycle(1'b1, NOP, 32'h8000018C, 32'h0);
        n_checks++; if (halt_o[3] !== 1'b1) $display("FAIL limit_halt: got %0h want 1", halt_o[3]); else n_pass++;
        n_checks++; if (reason_o[3] !== 2'd3) $display("FAIL limit_reason: got %0h want 3", reason_o[3]); else n_pass++;
        n_checks++; if (exit_o[3] !== 32'hFFFFFFFF) $display("FAIL limit_exit: got %0h want ffffffff", exit_o[3]); else n_pass++;
        n_checks++; if (cyc_o[3] !== 64'd100) $display("FAIL limit_cycle100: got %0d want 100", cyc_o[3]); else n_pass++;
        for (int c = 0; c < 5; c++) cycle(1'b1, NOP, 32'h80000190, 32'h0);
        n_checks++; if (cyc_o[3] !== 64'd100) $display("FAIL limit_cycle_frozen: got %0d want 100", cyc_o[3]); else n_pass++;
        n_checks++; if (ret_o[3] !== 64'd100) $display("FAIL limit_instret_frozen: got %0d want 100", ret_o[3]); else n_pass++;
        n_checks++; if (halt_o[3] !== 1'b1) $display("FAIL limit_sticky: got %0h want 1", halt_o[3]); else n_pass++;
    endtask

    task automatic test_ebreak_at_limit();
        do_reset();
        for (int c = 0; c < 99; c++) cycle(1'b1, NOP, 32'h80000000 + 32'(c * 4), 32'h5);
        cycle(1'b1, EBREAK, 32'h8000018C, 32'h5);
        n_checks++; if (reason_o[3] !== 2'd1) $display("FAIL lim_ebreak_reason: got %0h want 1", reason_o[3]); else n_pass++;
        n_checks++; if (stop_o[3] !== 1'b1) $display("FAIL lim_ebreak_stop: got %0h want 1", stop_o[3]); else n_pass++;
        n_checks++; if (halt_o[3] !== 1'b0) $display("FAIL lim_ebreak_drain: got %0h want 0", halt_o[3]); else n_pass++;
        n_checks++; if (exit_o[3] !== 32'h5) $display("FAIL lim_ebreak_exit: got %0h want 5", exit_o[3]); else n_pass++;
        cycle(1'b0, NOP, 32'h0, 32'h0);
        do_reset();
        n_checks++; if (stop_o[3] !== 1'b0) $display("FAIL drain_rst_stop: got %0h want 0", stop_o[3]); else n_pass++;
        n_checks++; if (reason_o[3] !== 2'd0) $display("FAIL drain_rst_reason: got %0h want 0", reason_o[3]); else n_pass++;
        n_checks++; if (exit_o[3] !== 32'h0) $display("FAIL drain_rst_exit: got %0h want 0", exit_o[3]); else n_pass++;
        n_checks++; if (cyc_o[3] !== 64'd0) $display("FAIL drain_rst_cycle: got %0d want 0", cyc_o[3]); else n_pass++;
        n_checks++; if (ret_o[3] !== 64'd0) $display("FAIL drain_rst_instret: got %0d want 0", ret_o[3]); else n_pass++;
        for (int c = 0; c < 3; c++) cycle(1'b1, NOP, 32'h80000000 + 32'(c * 4), 32'h0);
        cycle(1'b1, EBREAK, 32'h8000000C, 32'h0);
        cycle(1'b0, NOP, 32'h0, 32'h0);
        cycle(1'b0, NOP, 32'h0, 32'h0);
        n_checks++; if (halt_o[3] !== 1'b1) $display("FAIL retrap_halt: got %0h want 1", halt_o[3]); else n_pass++;
        n_checks++; if (good_o[3] !== 1'b1) $display("FAIL retrap_good: got %0h want 1", good_o[3]); else n_pass++;
        n_checks++; if (ret_o[3] !== 64'd4) $display("FAIL retrap_instret: got %0d want 4", ret_o[3]); else n_pass++;
        n_checks++; if (cyc_o[3] !== 64'd6) $display("FAIL retrap_cycle: got %0d want 6", cyc_o[3]); else n_pass++;
    endtask

    task automatic test_no_trigger();
        do_reset();
        cycle(1'b1, ECALL, 32'h80000000, 32'h7);
        cycle(1'b0, EBREAK, 32'h80000004, 32'h7);
        n_checks++; if (stop_o[0] !== 1'b0) $display("FAIL notrig_stop: got %0h want 0", stop_o[0]); else n_pass++;
        n_checks++; if (reason_o[0] !== 2'd0) $display("FAIL notrig_reason: got %0h want 0", reason_o[0]); else n_pass++;
        n_checks++; if (ret_o[0] !== 64'd1) $display("FAIL notrig_instret: got %0d want 1", ret_o[0]); else n_pass++;
        cycle(1'b1, EBREAK, 32'h80000100, 32'h11);
        cycle(1'b1, EBREAK, 32'h80000104, 32'h99);
        cycle(1'b1, EBREAK, 32'h80000108, 32'h99);
        n_checks++; if (halt_o[0] !== 1'b1) $display("FAIL pulse_halt: got %0h want 1", halt_o[0]); else n_pass++;
        n_checks++; if (ret_o[0] !== 64'd2) $display("FAIL pulse_instret: got %0d want 2", ret_o[0]); else n_pass++;
        n_checks++; if (exit_o[0] !== 32'h11) $display("FAIL pulse_exit: got %0h want 11", exit_o[0]); else n_pass++;
        n_checks++; if (hpc_o[0] !== 32'h80000100) $display("FAIL pulse_hpc: got %0h want 80000100", hpc_o[0]); else n_pass++;
        n_checks++; if (ret_o[1] !== 64'd2) $display("FAIL pulse_instret_nodrain: got %0d want 2", ret_o[1]); else n_pass++;
    endtask

    task automatic test_random();
        int          idle_pct, r;
        logic        v;
        logic [31:0] i, a;
        longint      e_cyc;
        logic        e_halt;
        for (int s = 0; s < 6; s++) begin
            do_reset();
            idle_pct = (s % 3 == 0) ? 10 : ((s % 3 == 1) ? 50 : 85);
            for (int c = 0; c < 150; c++) begin
                v = ($urandom_range(99) >= idle_pct);
                r = $urandom_range(99);
                i = (r < 3) ? EBREAK : ((r < 6) ? ECALL : $urandom());
                a = ($urandom_range(3) == 0) ? 32'h0 : $urandom();
                cycle(v, i, 32'h80000000 + 32'(c * 4), a);
                for (int k = 0; k < 4; k++) begin
                    e_halt = (t >= halt_at[k]);
                    e_cyc  = (t < halt_at[k]) ? t : halt_at[k];
                    n_checks++; if (stop_o[k] !== (t >= stop_at[k])) $display("FAIL rnd_stop[%0d] t=%0d: got %0h want %0h", k, t, stop_o[k], (t >= stop_at[k])); else n_pass++;
                    n_checks++; if (halt_o[k] !== e_halt) $display("FAIL rnd_halt[%0d] t=%0d: got %0h want %0h", k, t, halt_o[k], e_halt); else n_pass++;
                    n_checks++; if (reason_o[k] !== 2'(m_reason[k])) $display("FAIL rnd_reason[%0d] t=%0d: got %0h want %0h", k, t, reason_o[k], m_reason[k]); else n_pass++;
                    n_checks++; if (exit_o[k] !== m_exit[k]) $display("FAIL rnd_exit[%0d] t=%0d: got %0h want %0h", k, t, exit_o[k], m_exit[k]); else n_pass++;
                    n_checks++; if (hpc_o[k] !== m_hpc[k]) $display("FAIL rnd_hpc[%0d] t=%0d: got %0h want %0h", k, t, hpc_o[k], m_hpc[k]); else n_pass++;
                    n_checks++; if (good_o[k] !== (e_halt && m_reason[k] == 1 && m_exit[k] == 0)) $display("FAIL rnd_good[%0d] t=%0d: got %0h", k, t, good_o[k]); else n_pass++;
                    n_checks++; if (cyc_o[k] !== 64'(e_cyc)) $display("FAIL rnd_cycle[%0d] t=%0d: got %0d want %0d", k, t, cyc_o[k], e_cyc); else n_pass++;
                    n_checks++; if (ret_o[k] !== 64'(m_ret[k])) $display("FAIL rnd_instret[%0d] t=%0d: got %0d want %0d", k, t, ret_o[k], m_ret[k]); else n_pass++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ebreak_drain();
        test_ebreak_nodrain();
        test_watchdog();
        test_cycle_limit();
        test_ebreak_at_limit();
        test_no_trigger();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
